// File: rtl/alu_defs.sv
// Funct codes and sequencer state encodings shared by
// the execute-stage ALU and the multiply sequencer.
package alu_defs;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_RESP
  } state_t;

  function automatic logic is_alu_fn(
    input logic [5:0] f
  );
    return (f == FN_ADD) || (f == FN_SUB) ||
           (f == FN_AND) || (f == FN_OR)  ||
           (f == FN_XOR) || (f == FN_NOR) ||
           (f == FN_SRL) || (f == FN_SRA);
  endfunction

endpackage

// File: rtl/alu_mult_sequencer.sv
// Execute-stage owner of the shared ALU: single-cycle
// ops, MULTU via shift-add on the ALU adder, MFHI/MFLO.
module alu_mult_sequencer
  import alu_defs::*;
#(
  parameter int N_BITS   = 32,
  parameter int CNT_BITS = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [5:0]        i_funct,
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  output logic [N_BITS-1:0] o_alu_a,
  output logic [N_BITS-1:0] o_alu_b,
  output logic [5:0]        o_alu_op,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic              o_done,
  output logic [N_BITS-1:0] o_result,
  output logic              o_err,
  output logic [N_BITS-1:0] o_hi,
  output logic [N_BITS-1:0] o_lo
);

  localparam logic [CNT_BITS-1:0] LAST =
    CNT_BITS'(N_BITS - 1);

  state_t              state;
  state_t              state_n;
  logic [CNT_BITS-1:0] cnt;
  logic [N_BITS-1:0]   m;
  logic [N_BITS-1:0]   hi;
  logic [N_BITS-1:0]   lo;
  logic [N_BITS-1:0]   result;
  logic                err;
  logic [N_BITS-1:0]   sum;
  logic                carry;
  logic                last;

  assign o_ready  = (state == ST_IDLE);
  assign o_done   = (state == ST_RESP);
  assign o_result = result;
  assign o_err    = err;
  assign o_hi     = hi;
  assign o_lo     = lo;
  assign last     = (cnt == LAST);

  // Carry out of the 32-bit add is recovered by wraparound
  assign sum   = lo[0] ? i_alu_result : hi;
  assign carry = lo[0] && (i_alu_result < hi);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    o_alu_a  = '0;
    o_alu_b  = '0;
    o_alu_op = FN_ADD;
    unique case (state)
      ST_IDLE: begin
        if (i_valid) begin
          if (is_alu_fn(i_funct)) begin
            o_alu_a  = i_a;
            o_alu_b  = i_b;
            o_alu_op = i_funct;
          end
          state_n = (i_funct == FN_MULTU) ?
                    ST_MUL : ST_RESP;
        end
      end
      ST_MUL: begin
        o_alu_a = hi;
        o_alu_b = m;
        if (last) state_n = ST_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt    <= '0;
      m      <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_valid) begin
            err <= 1'b0;
            unique case (1'b1)
              is_alu_fn(i_funct):
                result <= i_alu_result;
              (i_funct == FN_MFHI):
                result <= hi;
              (i_funct == FN_MFLO):
                result <= lo;
              (i_funct == FN_MULTU): begin
                m   <= i_a;
                lo  <= i_b;
                hi  <= '0;
                cnt <= '0;
              end
              default: begin
                result <= '0;
                err    <= 1'b1;
              end
            endcase
          end
        end
        ST_MUL: begin
          hi  <= {carry, sum[N_BITS-1:1]};
          lo  <= {sum[0], lo[N_BITS-1:1]};
          cnt <= cnt + CNT_BITS'(1);
          if (last)
            result <= {sum[0], lo[N_BITS-1:1]};
        end
        ST_RESP: err <= 1'b0;
        default: err <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer with a
// behavioural ALU model beside it.
module tb_alu_mult_sequencer;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [5:0]  funct = 6'd0;
  logic [31:0] ia = '0;
  logic [31:0] ib = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_op;
  logic [31:0] alu_res;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;

  int nvec = 0;
  int nmis = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  alu_mult_sequencer #(.N_BITS(32), .CNT_BITS(6)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_valid(valid), .o_ready(ready),
    .i_funct(funct), .i_a(ia), .i_b(ib),
    .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_op(alu_op), .i_alu_result(alu_res),
    .o_done(done), .o_result(result),
    .o_err(err), .o_hi(hi), .o_lo(lo)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op)
      FN_ADD: alu_res = alu_a + alu_b;
      FN_SUB: alu_res = alu_a - alu_b;
      FN_AND: alu_res = alu_a & alu_b;
      FN_OR:  alu_res = alu_a | alu_b;
      FN_XOR: alu_res = alu_a ^ alu_b;
      FN_NOR: alu_res = ~(alu_a | alu_b);
      FN_SRL: alu_res = alu_a >> alu_b[4:0];
      FN_SRA: alu_res = $signed(alu_a) >>> alu_b[4:0];
      default: alu_res = '0;
    endcase
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_done: got result %h",
                 result);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("done_result", result, e[31:0]);
        chk("done_err", {31'd0, err}, {31'd0, e[32]});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [5:0]  f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] er,
                       input logic        ee);
    wait_ready();
    funct = f; ia = a; ib = b; valid = 1'b1;
    #1;
    if (is_alu_fn(f)) begin
      chk("alu_op", {26'd0, alu_op}, {26'd0, f});
      chk("alu_a", alu_a, a);
    end
    exp_q.push_back({ee, er});
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    int c;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_op", {26'd0, alu_op}, {26'd0, FN_ADD});
    chk("idle_alu_b", alu_b, 32'd0);

    issue(FN_ADD, 32'd7, 32'd9, 32'd16, 1'b0);
    issue(FN_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
    issue(FN_NOR, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);
    issue(FN_AND, 32'h0000F0F0, 32'h0000FF00,
          32'h0000F000, 1'b0);
    issue(FN_XOR, 32'hA5A5A5A5, 32'hFFFF0000,
          32'h5A5AA5A5, 1'b0);
    issue(FN_SRL, 32'h80000000, 32'd4,
          32'h08000000, 1'b0);
    issue(FN_SRA, 32'h80000000, 32'd4,
          32'hF8000000, 1'b0);

    // MULTU 3x5 and its busy window
    issue(FN_MULTU, 32'd3, 32'd5, 32'd15, 1'b0);
    c = 0;
    while (!ready && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk("mul_busy_cycles", c, 32'd33);
    issue(FN_MFLO, 32'd0, 32'd0, 32'd15, 1'b0);
    issue(FN_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);

    issue(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'h00000001, 1'b0);
    wait_ready();
    chk("max_hi", hi, 32'hFFFFFFFE);
    chk("max_lo", lo, 32'h00000001);

    issue(6'b111111, 32'd1, 32'd2, 32'd0, 1'b1);
    wait_ready();
    chk("bad_hi", hi, 32'hFFFFFFFE);
    chk("bad_lo", lo, 32'h00000001);

    // ADD held valid during a multiply is dropped
    wait_ready();
    funct = FN_MULTU; ia = 32'd6; ib = 32'd7;
    valid = 1'b1;
    exp_q.push_back({1'b0, 32'd42});
    @(posedge clk); #1;
    funct = FN_ADD; ia = 32'd1; ib = 32'd1;
    c = 0;
    while (!done && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (!done) chk("held_timeout", 32'd0, 32'd1);
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held_lo", lo, 32'd42);
    chk("held_hi", hi, 32'd0);

    // Reset in the middle of a multiply
    wait_ready();
    funct = FN_MULTU; ia = 32'd7; ib = 32'd9;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mrst_ready", {31'd0, ready}, 32'd1);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_ready_rel", {31'd0, ready}, 32'd1);
    issue(FN_MFLO, 32'd0, 32'd0, 32'd0, 1'b0);
    issue(FN_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);
    issue(FN_OR, 32'h00FF0000, 32'h000000FF,
          32'h00FF00FF, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
Execute-stage controller that owns the shared 32-bit ALU and sequences every ALU request through it.
- Single-cycle functs (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR) pass straight to the ALU and return a registered result.
- MULTU runs as a 32-iteration shift-add sequence that reuses the ALU adder, and loads the HI/LO registers.
- MFHI/MFLO read HI/LO back.
- Sits between the ID/EX pipeline register and the ALU; o_ready stalls the pipeline while a multiply is in flight.

Parameters:
- N_BITS, 32, datapath width; shared with the ALU.
- CNT_BITS, 6, iteration counter width; must satisfy 2^CNT_BITS > N_BITS.

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  request present this cycle
- o_ready  out  1  block can accept a request (IDLE only)
- i_funct  in  6  MIPS R-type funct code
- i_a  in  N_BITS  operand A (rs)
- i_b  in  N_BITS  operand B (rt, or shift amount)
- o_alu_a  out  N_BITS  ALU operand A
- o_alu_b  out  N_BITS  ALU operand B
- o_alu_op  out  6  ALU operation code
- i_alu_result  in  N_BITS  ALU combinational result
- o_done  out  1  one-cycle pulse: o_result/o_err valid
- o_result  out  N_BITS  result of the completed request
- o_err  out  1  completed request had an unsupported funct
- o_hi  out  N_BITS  HI register
- o_lo  out  N_BITS  LO register

Behaviour:
- Reset:
  - Asynchronous; state=IDLE, counter=0.
  - o_done=0, o_err=0, o_result=0, o_hi=0, o_lo=0.
  - o_ready=1 once reset deasserts.
  - Reset during MUL aborts the multiply; HI/LO stay 0.
- Accept: i_valid & o_ready. Requests with i_valid high while o_ready=0 are ignored, not queued.
- States:
  - IDLE -> RESP: ALU funct, MFHI, MFLO, unsupported funct.
  - IDLE -> MUL: MULTU (6'b011001).
  - MUL -> RESP: after iteration 32.
  - RESP -> IDLE: unconditional.
- IDLE, ALU path:
  - o_alu_a=i_a, o_alu_b=i_b, o_alu_op=i_funct.
  - On accept, register i_alu_result into o_result.
  - o_done=1 in RESP, the cycle after accept (latency 1).
- IDLE, MFHI (6'b010000) / MFLO (6'b010010): o_result=HI/LO, latency 1, HI/LO unchanged.
- Unsupported funct: o_result=0, o_err=1 with the o_done pulse. o_err is 0 for all other completions.
- IDLE, no valid request: o_alu_op=ADD (6'b100000), o_alu_a=o_alu_b=0.
- MULTU:
  - On accept: multiplicand M=i_a, LO=i_b, HI=0, counter=0.
  - Each MUL cycle drives o_alu_a=HI, o_alu_b=M, o_alu_op=ADD.
  - If LO[0]=1: sum=i_alu_result and carry=(sum < HI), unsigned compare; else sum=HI, carry=0.
  - Then {HI,LO} <= {carry, sum, LO[N_BITS-1:1]}, i.e. the 65-bit value {carry,sum,LO} shifted right by 1.
  - Counter increments; after the N_BITS-th iteration go to RESP with o_result=LO (final).
  - Accept at cycle 0, iterations in cycles 1..32, o_done at cycle 33, o_ready=1 at cycle 34.
  - o_hi/o_lo show intermediate values during MUL and are architecturally valid only from RESP onward.
- o_ready=1 only in IDLE, so back-to-back single-cycle ops complete every 2 cycles.
- RESP is the only state in which o_done=1. o_result holds its value until the next completion.

Decomposition:
- Shared package/header alu_defs: funct localparams (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SRA, FN_SRL, FN_NOR, FN_MULTU, FN_MFHI, FN_MFLO) and state encodings (ST_IDLE, ST_MUL, ST_RESP). The existing ALU also moves to these funct constants.
- No sub-module. The ALU is instantiated beside this block at execute-stage level.

Test Plan:
- ADD a=7, b=9 in IDLE -> o_alu_op=6'b100000 same cycle; next cycle o_done=1, o_result=16, o_err=0.
- SUB a=3, b=5 -> o_result=0xFFFFFFFE, latency 1; then NOR a=0, b=0 accepted when o_ready=1 -> o_result=0xFFFFFFFF.
- MULTU 3×5 -> o_ready=0 for cycles 1..33; o_done at cycle 33; then MFLO -> 15, MFHI -> 0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; exercises the carry path on every iteration.
- i_valid held high with ADD during MUL -> ignored; exactly one o_done (the MULTU) before IDLE.
- Reset asserted at MUL iteration 10 -> all outputs 0 asynchronously, state IDLE, o_ready=1 after release.
- Funct 6'b111111 -> o_done=1, o_err=1, o_result=0; HI/LO unchanged.
